// File: rtl/parking_lot_ctrl.sv
// Multi-gate car-park occupancy controller: per-gate entry/exit barrier FSMs,
// slot reservation so concurrent gates cannot over-fill the lot, and per-barrier open-timeout alarms.
module parking_lot_ctrl #(
   parameter int CAPACITY = 10,
   parameter int NGATES   = 2,
   parameter int TIMEOUT  = 8,
   parameter int CW       = $clog2(CAPACITY + 1)
) (
   input  logic              clk_2,
   input  logic              reset,
   input  logic [NGATES-1:0] entry_sensor,
   input  logic [NGATES-1:0] exit_sensor,
   output logic [NGATES-1:0] entry_open,
   output logic [NGATES-1:0] exit_open,
   output logic [NGATES-1:0] entry_alarm,
   output logic [NGATES-1:0] exit_alarm,
   output logic [CW-1:0]     occupied,
   output logic [CW-1:0]     free_slots,
   output logic              full,
   output logic              empty
);

   localparam int CW1 = CW + 1;
   localparam int TW  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {E_IDLE, E_OPEN, E_PASS} e_state_t;
   typedef enum logic [1:0] {X_IDLE, X_OPEN, X_PASS} x_state_t;

   e_state_t      e_state [NGATES];
   x_state_t      x_state [NGATES];
   logic [TW-1:0] e_cnt   [NGATES];
   logic [TW-1:0] x_cnt   [NGATES];

   logic [CW-1:0] occ_q;
   logic [CW-1:0] res_in_q;
   logic [CW-1:0] res_out_q;

   logic [NGATES-1:0] e_grant;
   logic [NGATES-1:0] x_grant;
   logic              e_found;
   logic              x_found;
   logic              e_room;
   logic              x_avail;
   logic [CW1-1:0]    committed;
   logic [CW-1:0]     occ_nx;
   logic [CW-1:0]     res_in_nx;
   logic [CW-1:0]     res_out_nx;

   // Grant arbitration and the net counter change for this cycle, from registered state only.
   always_comb begin
      e_grant    = '0;
      x_grant    = '0;
      e_found    = 1'b0;
      x_found    = 1'b0;
      committed  = {1'b0, occ_q} + {1'b0, res_in_q};
      e_room     = committed < CW1'(CAPACITY);
      x_avail    = occ_q > res_out_q;
      for (int g = 0; g < NGATES; g++) begin
         if (!e_found && e_room && (e_state[g] == E_IDLE) && entry_sensor[g]) begin
            e_grant[g] = 1'b1;
            e_found    = 1'b1;
         end
         if (!x_found && x_avail && (x_state[g] == X_IDLE) && exit_sensor[g]) begin
            x_grant[g] = 1'b1;
            x_found    = 1'b1;
         end
      end

      // Add the new reservations first so intermediate values never underflow.
      occ_nx     = occ_q;
      res_in_nx  = res_in_q + CW'(e_found);
      res_out_nx = res_out_q + CW'(x_found);
      for (int g = 0; g < NGATES; g++) begin
         if (e_state[g] == E_PASS) begin
            occ_nx    = occ_nx + CW'(1);
            res_in_nx = res_in_nx - CW'(1);
         end
         if (x_state[g] == X_PASS) begin
            occ_nx     = occ_nx - CW'(1);
            res_out_nx = res_out_nx - CW'(1);
         end
      end
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         occ_q      <= '0;
         res_in_q   <= '0;
         res_out_q  <= '0;
         entry_open <= '0;
         exit_open  <= '0;
         for (int g = 0; g < NGATES; g++) begin
            e_state[g] <= E_IDLE;
            x_state[g] <= X_IDLE;
            e_cnt[g]   <= '0;
            x_cnt[g]   <= '0;
         end
      end else begin
         occ_q     <= occ_nx;
         res_in_q  <= res_in_nx;
         res_out_q <= res_out_nx;
         for (int g = 0; g < NGATES; g++) begin
            // Open counter starts at 1 so the alarm lands on the TIMEOUT-th open cycle.
            case (e_state[g])
               E_IDLE: begin
                  if (e_grant[g]) begin
                     e_state[g]    <= E_OPEN;
                     e_cnt[g]      <= TW'(1);
                     entry_open[g] <= 1'b1;
                  end
               end
               E_OPEN: begin
                  if (!entry_sensor[g]) begin
                     e_state[g]    <= E_PASS;
                     e_cnt[g]      <= '0;
                     entry_open[g] <= 1'b0;
                  end else if (e_cnt[g] != TW'(TIMEOUT)) begin
                     e_cnt[g] <= e_cnt[g] + TW'(1);
                  end
               end
               E_PASS: begin
                  e_state[g] <= E_IDLE;
               end
               default: begin
                  e_state[g]    <= E_IDLE;
                  e_cnt[g]      <= '0;
                  entry_open[g] <= 1'b0;
               end
            endcase

            case (x_state[g])
               X_IDLE: begin
                  if (x_grant[g]) begin
                     x_state[g]   <= X_OPEN;
                     x_cnt[g]     <= TW'(1);
                     exit_open[g] <= 1'b1;
                  end
               end
               X_OPEN: begin
                  if (!exit_sensor[g]) begin
                     x_state[g]   <= X_PASS;
                     x_cnt[g]     <= '0;
                     exit_open[g] <= 1'b0;
                  end else if (x_cnt[g] != TW'(TIMEOUT)) begin
                     x_cnt[g] <= x_cnt[g] + TW'(1);
                  end
               end
               X_PASS: begin
                  x_state[g] <= X_IDLE;
               end
               default: begin
                  x_state[g]   <= X_IDLE;
                  x_cnt[g]     <= '0;
                  exit_open[g] <= 1'b0;
               end
            endcase
         end
      end
   end

   always_comb begin
      entry_alarm = '0;
      exit_alarm  = '0;
      for (int g = 0; g < NGATES; g++) begin
         entry_alarm[g] = (e_cnt[g] == TW'(TIMEOUT));
         exit_alarm[g]  = (x_cnt[g] == TW'(TIMEOUT));
      end
   end

   assign occupied   = occ_q;
   assign free_slots = CW'(CAPACITY) - occ_q - res_in_q;
   assign full       = (free_slots == '0);
   assign empty      = (occ_q == '0);

endmodule

// File: doc/parking_lot_ctrl.md
# parking_lot_ctrl

Multi-gate car-park occupancy controller for the FPGA board top level. It supports NGATES independent gate pairs (one entry barrier and one exit barrier each) and a parametrised capacity. Slot reservation makes over-filling impossible even when several gates operate at once. It also raises a per-barrier timeout alarm. It sits between the debounced switch inputs and the LED/LCD display logic.

## Interface
- CAPACITY, 10: maximum cars in the lot (≥1).
- NGATES, 2: number of gate pairs (≥1).
- TIMEOUT, 8: cycles a barrier may stay open before its alarm asserts (≥1).
- CW, $clog2(CAPACITY+1): width of the count outputs.
- clk_2  in  1: single clock, rising edge.
- reset  in  1: synchronous, active-high.
- entry_sensor  in  NGATES: car present at entry barrier g.
- exit_sensor  in  NGATES: car present at exit barrier g.
- entry_open  out  NGATES: entry barrier g raised.
- exit_open  out  NGATES: exit barrier g raised.
- entry_alarm  out  NGATES: entry barrier g open ≥ TIMEOUT cycles.
- exit_alarm  out  NGATES: exit barrier g open ≥ TIMEOUT cycles.
- occupied  out  CW: cars committed inside the lot.
- free_slots  out  CW: CAPACITY − occupied − reserved_in.
- full  out  1: free_slots == 0.
- empty  out  1: occupied == 0.

## Operation
- Internal counters: occupied, reserved_in (entries granted but not completed), reserved_out (exits granted but not completed). All are CW bits wide.
- Entry FSM per gate:
  - E_IDLE: if entry_sensor[g] is high and the gate holds the entry grant, go to E_OPEN and increment reserved_in.
  - E_OPEN: if entry_sensor[g] is low, go to E_PASS.
  - E_PASS: increment occupied, decrement reserved_in, go to E_IDLE.
- Exit FSM per gate:
  - X_IDLE: if exit_sensor[g] is high and the gate holds the exit grant, go to X_OPEN and increment reserved_out.
  - X_OPEN: if exit_sensor[g] is low, go to X_PASS.
  - X_PASS: decrement occupied, decrement reserved_out, go to X_IDLE.
- Entry grant:
  - At most one per cycle, to the lowest-index gate that is in E_IDLE with its sensor high.
  - Only given when occupied + reserved_in < CAPACITY.
  - A denied gate stays in E_IDLE and retries every cycle.
- Exit grant:
  - At most one per cycle, to the lowest-index gate that is in X_IDLE with its sensor high.
  - Only given when occupied − reserved_out > 0.
  - Cars still in reservation cannot exit.
- Counter updates in one cycle are summed into a single net change:
  - any number of E_PASS and X_PASS completions across gates;
  - one new entry grant;
  - one new exit grant.
- Invariants: 0 ≤ occupied ≤ CAPACITY, and occupied + reserved_in ≤ CAPACITY. No wrap-around is possible.
- Alarm: a per-barrier open counter increments while the barrier is in OPEN and saturates at TIMEOUT. Alarm = (counter == TIMEOUT). Leaving OPEN clears the counter and the alarm. An alarm does not force the barrier closed.
- Reset:
  - Reset has priority over all other logic.
  - It returns all FSMs to IDLE and clears all counters and outputs, including mid-passage. A car partway through is discarded.
- Reset values:
  - entry_open, exit_open, entry_alarm, exit_alarm = 0.
  - occupied = 0, free_slots = CAPACITY, full = 0, empty = 1.

## Timing
- All outputs are registered or decoded Moore-style from registered state. There is no combinational sensor-to-output path.
- Entry pass:
  - Sensor high sampled at edge t (gate idle, granted): entry_open = 1 and free_slots decremented from cycle t+1.
  - Sensor low sampled at edge u while open: entry_open = 0 from u+1 (E_PASS).
  - occupied incremented from u+2.
- Exit pass: same cycle pattern, with occupied decremented from u+2.
- Minimum full passage: 3 cycles (IDLE→OPEN→PASS→IDLE).
- The alarm asserts on the TIMEOUT-th cycle of continuous OPEN. It deasserts in the cycle the FSM reaches PASS.
- Simultaneous events:
  - Entry completion and exit completion in the same cycle: net occupied change 0.
  - Two entry requests in the same cycle: the lower index opens first, the higher index opens the next cycle if capacity remains.
- Reset asserted at edge t: all outputs at reset values from t+1. Operation resumes at the first edge with reset low.

## Test plan
- Reset values: CAPACITY=3, NGATES=2. Hold reset for 2 cycles → occupied=0, free_slots=3, empty=1, full=0, all open/alarm=0.
- Single entry: pulse entry_sensor[0] high 2 cycles then low → entry_open[0] for exactly 2 cycles, starting 1 cycle after sensor rise. free_slots=2 from the open cycle. occupied=1 two cycles after the sensor falls.
- Full lot: fill to 3 cars, then raise entry_sensor[1] for 10 cycles → entry_open[1] stays 0, full=1. Complete one exit → entry_open[1] rises within 2 cycles of occupied dropping to 2.
- Contention: occupied=2, raise entry_sensor[0] and entry_sensor[1] in the same cycle → only gate 0 opens. Gate 1 never opens because occupied + reserved_in = 3, full=1. Occupied ends at 3, never 4.
- Empty/simultaneous: occupied=1 with one entry and one exit completing in the same cycle → occupied stays 1. With occupied=0, exit_sensor[0] high → exit_open[0] never asserts.
- Timeout and reset: TIMEOUT=8, hold entry_sensor[0] high → entry_alarm[0] rises on the 8th open cycle. Assert reset while open → all outputs return to reset values next cycle and occupied=0.
